// File: rtl/keymatrix_pkg.sv
// keymatrix_pkg
//   Shared definitions for the PS/2-to-ZX-Spectrum keyboard matrix:
//   prefix FSM states, set-2 prefix bytes, compound-key identifiers and
//   the scancode -> (row, col) matrix table.
package keymatrix_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK,
      ST_SKIP
   } state_t;

   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_F0 = 8'hF0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_AA = 8'hAA;

   // Compound keys: each one asserts CS plus the key given by cmp_pos().
   localparam logic [2:0] CMP_NONE  = 3'd0;
   localparam logic [2:0] CMP_BKSP  = 3'd1;
   localparam logic [2:0] CMP_LEFT  = 3'd2;
   localparam logic [2:0] CMP_DOWN  = 3'd3;
   localparam logic [2:0] CMP_UP    = 3'd4;
   localparam logic [2:0] CMP_RIGHT = 3'd5;
   localparam int         NUM_CMP   = 5;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_NMI,
      SEL_BOOT
   } sel_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] row;
      logic [2:0] col;
   } pos_t;

   function automatic pos_t mk(input int r, input int c);
      mk = '{valid: 1'b1, row: 3'(r), col: 3'(c)};
   endfunction

   // Non-extended set-2 code -> matrix position.
   function automatic pos_t key_pos(input logic [7:0] code);
      case (code)
         8'h12, 8'h59: key_pos = mk(0, 0);  // CS (both shifts)
         8'h1A: key_pos = mk(0, 1);  8'h22: key_pos = mk(0, 2);
         8'h21: key_pos = mk(0, 3);  8'h2A: key_pos = mk(0, 4);
         8'h1C: key_pos = mk(1, 0);  8'h1B: key_pos = mk(1, 1);
         8'h23: key_pos = mk(1, 2);  8'h2B: key_pos = mk(1, 3);
         8'h34: key_pos = mk(1, 4);
         8'h15: key_pos = mk(2, 0);  8'h1D: key_pos = mk(2, 1);
         8'h24: key_pos = mk(2, 2);  8'h2D: key_pos = mk(2, 3);
         8'h2C: key_pos = mk(2, 4);
         8'h16: key_pos = mk(3, 0);  8'h1E: key_pos = mk(3, 1);
         8'h26: key_pos = mk(3, 2);  8'h25: key_pos = mk(3, 3);
         8'h2E: key_pos = mk(3, 4);
         8'h45: key_pos = mk(4, 0);  8'h46: key_pos = mk(4, 1);
         8'h3E: key_pos = mk(4, 2);  8'h3D: key_pos = mk(4, 3);
         8'h36: key_pos = mk(4, 4);
         8'h4D: key_pos = mk(5, 0);  8'h44: key_pos = mk(5, 1);
         8'h43: key_pos = mk(5, 2);  8'h3C: key_pos = mk(5, 3);
         8'h35: key_pos = mk(5, 4);
         8'h5A: key_pos = mk(6, 0);  8'h4B: key_pos = mk(6, 1);
         8'h42: key_pos = mk(6, 2);  8'h3B: key_pos = mk(6, 3);
         8'h33: key_pos = mk(6, 4);
         8'h29: key_pos = mk(7, 0);  8'h14: key_pos = mk(7, 1);
         8'h3A: key_pos = mk(7, 2);  8'h31: key_pos = mk(7, 3);
         8'h32: key_pos = mk(7, 4);
         default: key_pos = '0;
      endcase
   endfunction

   // Second key contributed by a compound flag (CS is implied).
   function automatic pos_t cmp_pos(input logic [2:0] id);
      case (id)
         CMP_BKSP:  cmp_pos = mk(4, 0);
         CMP_LEFT:  cmp_pos = mk(3, 4);
         CMP_DOWN:  cmp_pos = mk(4, 4);
         CMP_UP:    cmp_pos = mk(4, 3);
         CMP_RIGHT: cmp_pos = mk(4, 2);
         default:   cmp_pos = '0;
      endcase
   endfunction

endpackage

// File: rtl/keymatrix_if.sv
// keymatrix_if
//   Bundles the receiver byte stream (strb/code), the CPU row select and
//   the matrix answer (col, nmi, boot).
//   master: drives strb, code, row; samples col, nmi, boot.
//   slave : the keymatrix block.
interface keymatrix_if;
   logic       strb;
   logic [7:0] code;
   logic [7:0] row;
   logic [4:0] col;
   logic       nmi;
   logic       boot;

   modport master (output strb, code, row, input col, nmi, boot);
   modport slave  (input strb, code, row, output col, nmi, boot);
endinterface

// File: rtl/keymatrix_decode.sv
// keymatrix_decode
//   Combinational lookup of an (extended, code) pair.
//   i_ext   : byte was preceded by E0
//   i_code  : set-2 byte
//   o_valid : code maps to a direct matrix position o_row/o_col
//   o_cmp   : compound-key id (CMP_NONE if none)
//   o_sel   : nmi/boot select
module keymatrix_decode
   import keymatrix_pkg::*;
(
   input  logic       i_ext,
   input  logic [7:0] i_code,
   output logic       o_valid,
   output logic [2:0] o_row,
   output logic [2:0] o_col,
   output logic [2:0] o_cmp,
   output sel_t       o_sel
);

   pos_t w_pos;

   always_comb begin
      w_pos = '0;
      o_cmp = CMP_NONE;
      o_sel = SEL_NONE;
      if (!i_ext) begin
         w_pos = key_pos(i_code);
         case (i_code)
            8'h66:   o_cmp = CMP_BKSP;
            8'h03:   o_sel = SEL_NMI;
            8'h07:   o_sel = SEL_BOOT;
            default: ;
         endcase
      end else begin
         // Only SS and Enter have extended twins; E0 12 is a fake shift.
         case (i_code)
            8'h14, 8'h5A: w_pos = key_pos(i_code);
            8'h6B:   o_cmp = CMP_LEFT;
            8'h72:   o_cmp = CMP_DOWN;
            8'h75:   o_cmp = CMP_UP;
            8'h74:   o_cmp = CMP_RIGHT;
            default: ;
         endcase
      end
   end

   assign o_valid = w_pos.valid;
   assign o_row   = w_pos.row;
   assign o_col   = w_pos.col;

endmodule

// File: rtl/keymatrix.sv
// keymatrix
//   Turns the PS/2 set-2 byte stream into a live ZX Spectrum 8x5 matrix.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : keymatrix_if.slave (strb, code, row in; col, nmi, boot out)
//   SKIP_E1 : bytes swallowed after an E1 (Pause) prefix.
module keymatrix
   import keymatrix_pkg::*;
#(
   parameter int SKIP_E1 = 7
) (
   input logic         clock,
   input logic         reset,
   keymatrix_if.slave  bus
);

   localparam int CNT_W = (SKIP_E1 < 2) ? 1 : $clog2(SKIP_E1 + 1);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0][4:0]   r_key;
   logic [NUM_CMP-1:0] r_cmp;
   logic              r_nmi, r_boot;
   logic [4:0]        r_col_p1;

   logic              w_ext, w_apply, w_make, w_clear;
   logic              w_dvalid;
   logic [2:0]        w_drow, w_dcol, w_dcmp;
   sel_t              w_dsel;
   logic [7:0][4:0]   w_eff;
   pos_t              w_cp;
   logic [4:0]        w_any;

   keymatrix_decode u_decode (
      .i_ext   (w_ext),
      .i_code  (bus.code),
      .o_valid (w_dvalid),
      .o_row   (w_drow),
      .o_col   (w_dcol),
      .o_cmp   (w_dcmp),
      .o_sel   (w_dsel)
   );

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ext   = (r_state == ST_EXT) || (r_state == ST_EXTBRK);
      w_apply = 1'b0;
      w_make  = 1'b0;
      w_clear = 1'b0;
      case (r_state)
         ST_IDLE: if (bus.strb) begin
            if      (bus.code == SC_E0) w_next = ST_EXT;
            else if (bus.code == SC_F0) w_next = ST_BRK;
            else if (bus.code == SC_E1) w_next = ST_SKIP;
            else if (bus.code == SC_AA) w_clear = 1'b1;
            else begin
               w_apply = 1'b1;
               w_make  = 1'b1;
            end
         end
         ST_EXT: if (bus.strb) begin
            if (bus.code == SC_F0) w_next = ST_EXTBRK;
            else begin
               w_apply = 1'b1;
               w_make  = 1'b1;
               w_next  = ST_IDLE;
            end
         end
         ST_BRK, ST_EXTBRK: if (bus.strb) begin
            w_apply = 1'b1;
            w_next  = ST_IDLE;
         end
         // Leave on the byte that brings the counter to zero.
         ST_SKIP: if (bus.strb && (r_cnt <= CNT_W'(1))) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         r_cnt <= '0;
      else if ((r_state == ST_IDLE) && bus.strb && (bus.code == SC_E1))
         r_cnt <= CNT_W'(SKIP_E1);
      else if ((r_state == ST_SKIP) && bus.strb && (r_cnt != '0))
         r_cnt <= r_cnt - CNT_W'(1);
   end

   // Non-key bytes fall through the decoder as unmapped, so they only
   // steer the FSM back to IDLE.
   always_ff @(posedge clock) begin
      if (reset || w_clear) begin
         r_key  <= '0;
         r_cmp  <= '0;
         r_nmi  <= 1'b0;
         r_boot <= 1'b0;
      end else if (w_apply) begin
         if (w_dvalid)            r_key[w_drow][w_dcol]   <= w_make;
         if (w_dcmp != CMP_NONE)  r_cmp[w_dcmp - 3'd1]    <= w_make;
         if (w_dsel == SEL_NMI)   r_nmi                   <= w_make;
         if (w_dsel == SEL_BOOT)  r_boot                  <= w_make;
      end
   end

   // Compound flags are ORed on top of the direct bits, so releasing a
   // compound key never clears a physically held CS.
   always_comb begin
      w_eff = r_key;
      w_cp  = '0;
      for (int i = 0; i < NUM_CMP; i++) begin
         w_cp = cmp_pos(3'(i + 1));
         if (r_cmp[i]) begin
            w_eff[0][0]                = 1'b1;
            w_eff[w_cp.row][w_cp.col]  = 1'b1;
         end
      end
   end

   always_comb begin
      w_any = '0;
      for (int r = 0; r < 8; r++)
         if (!bus.row[r]) w_any = w_any | w_eff[r];
   end

   // Stage p1: registered active-low column answer
   always_ff @(posedge clock) begin
      if (reset) r_col_p1 <= 5'h1F;
      else       r_col_p1 <= ~w_any;
   end

   assign bus.col  = r_col_p1;
   assign bus.nmi  = r_nmi;
   assign bus.boot = r_boot;

endmodule

// File: tb/tb_keymatrix.sv
// tb_keymatrix
//   Directed scenarios followed by randomized press/release traffic,
//   checked against a reference model that keeps the set of held keys
//   and derives the matrix from it.
module tb_keymatrix;

   localparam int SKIP = 7;

   logic clock = 1'b0;
   logic reset = 1'b1;
   keymatrix_if bus();

   keymatrix #(.SKIP_E1(SKIP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: prefix tracking plus the set of held keys,
   // keyed by {extended, code}.
   bit held[int];
   bit m_ext = 1'b0;
   bit m_brk = 1'b0;
   int m_skip = 0;

   function automatic logic [39:0] bp(input int r, input int c);
      return 40'd1 << (r * 5 + c);
   endfunction

   function automatic logic [39:0] mask_of(input int k);
      case (k)
         'h012, 'h059: return bp(0, 0);
         'h01A: return bp(0, 1);  'h022: return bp(0, 2);
         'h021: return bp(0, 3);  'h02A: return bp(0, 4);
         'h01C: return bp(1, 0);  'h01B: return bp(1, 1);
         'h023: return bp(1, 2);  'h02B: return bp(1, 3);
         'h034: return bp(1, 4);
         'h015: return bp(2, 0);  'h01D: return bp(2, 1);
         'h024: return bp(2, 2);  'h02D: return bp(2, 3);
         'h02C: return bp(2, 4);
         'h016: return bp(3, 0);  'h01E: return bp(3, 1);
         'h026: return bp(3, 2);  'h025: return bp(3, 3);
         'h02E: return bp(3, 4);
         'h045: return bp(4, 0);  'h046: return bp(4, 1);
         'h03E: return bp(4, 2);  'h03D: return bp(4, 3);
         'h036: return bp(4, 4);
         'h04D: return bp(5, 0);  'h044: return bp(5, 1);
         'h043: return bp(5, 2);  'h03C: return bp(5, 3);
         'h035: return bp(5, 4);
         'h05A, 'h15A: return bp(6, 0);
         'h04B: return bp(6, 1);  'h042: return bp(6, 2);
         'h03B: return bp(6, 3);  'h033: return bp(6, 4);
         'h029: return bp(7, 0);
         'h014, 'h114: return bp(7, 1);
         'h03A: return bp(7, 2);  'h031: return bp(7, 3);
         'h032: return bp(7, 4);
         'h066: return bp(0, 0) | bp(4, 0);
         'h16B: return bp(0, 0) | bp(3, 4);
         'h172: return bp(0, 0) | bp(4, 4);
         'h175: return bp(0, 0) | bp(4, 3);
         'h174: return bp(0, 0) | bp(4, 2);
         default: return 40'd0;
      endcase
   endfunction

   function automatic void model_clear();
      held.delete();
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_skip = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int k;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      if (!m_ext && !m_brk) begin
         if (b == 8'hE0) begin m_ext = 1'b1; return; end
         if (b == 8'hF0) begin m_brk = 1'b1; return; end
         if (b == 8'hE1) begin m_skip = SKIP; return; end
         if (b == 8'hAA) begin held.delete(); return; end
      end else if (m_ext && !m_brk && b == 8'hF0) begin
         m_brk = 1'b1;
         return;
      end
      k = (m_ext ? 'h100 : 0) | int'(b);
      if (m_brk) held.delete(k);
      else       held[k] = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
   endfunction

   function automatic logic [4:0] model_col(input logic [7:0] row);
      logic [39:0] eff;
      logic [4:0]  acc;
      eff = '0;
      acc = '0;
      foreach (held[k]) eff |= mask_of(k);
      for (int r = 0; r < 8; r++)
         if (!row[r]) acc |= eff[r*5 +: 5];
      return ~acc;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at #1 after a rising edge; consecutive calls give back-to-back strobes.
   task automatic send(input logic [7:0] b);
      bus.strb = 1'b1;
      bus.code = b;
      model_byte(b);
      @(posedge clock); #1;
      bus.strb = 1'b0;
   endtask

   task automatic press(input int k);
      if (k >= 'h100) send(8'hE0);
      send(8'(k));
   endtask

   task automatic release_key(input int k);
      if (k >= 'h100) send(8'hE0);
      send(8'hF0);
      send(8'(k));
   endtask

   task automatic col_is(input string tag, input logic [7:0] row, input logic [4:0] exp);
      bus.row = row;
      @(posedge clock); #1;
      chk(tag, {3'b0, bus.col}, {3'b0, exp});
   endtask

   task automatic do_reset();
      bus.strb = 1'b0;
      bus.row  = 8'h00;
      reset    = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      chk("reset_col",  {3'b0, bus.col}, 8'h1F);
      chk("reset_nmi",  {7'b0, bus.nmi}, 8'h00);
      chk("reset_boot", {7'b0, bus.boot}, 8'h00);
      reset = 1'b0;
      model_clear();
   endtask

   int pool[$] = '{'h012, 'h01A, 'h022, 'h021, 'h02A, 'h01C, 'h01B, 'h023,
                   'h02B, 'h034, 'h015, 'h01D, 'h024, 'h02D, 'h02C, 'h016,
                   'h01E, 'h026, 'h025, 'h02E, 'h045, 'h046, 'h03E, 'h03D,
                   'h036, 'h04D, 'h044, 'h043, 'h03C, 'h035, 'h15A, 'h04B,
                   'h042, 'h03B, 'h033, 'h029, 'h014, 'h03A, 'h031, 'h032,
                   'h066, 'h16B, 'h172, 'h175, 'h174, 'h003, 'h007, 'h112,
                   'h00D, 'h076};
   logic [7:0] noise[5] = '{8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   initial begin
      int         k, op;
      logic [7:0] rsel;
      bus.strb = 1'b0;
      bus.code = 8'h00;
      bus.row  = 8'hFF;
      @(posedge clock); #1;

      do_reset();

      // Direct key, with strobe-to-col latency
      bus.row = 8'hFD;
      @(posedge clock); #1;
      send(8'h1C);
      chk("lat_old", {3'b0, bus.col}, 8'h1F);
      @(posedge clock); #1;
      chk("lat_new", {3'b0, bus.col}, 8'h1E);
      // Row-to-col latency is one cycle
      bus.row = 8'hFF;
      @(posedge clock); #1;
      chk("row_lat", {3'b0, bus.col}, 8'h1F);
      col_is("direct_A", 8'hFD, 5'h1E);
      send(8'hF0); send(8'h1C);
      col_is("direct_A_rel", 8'hFD, 5'h1F);

      // Compound: cursor up = CS + 7
      send(8'hE0); send(8'h75);
      col_is("cmp_up_cs", 8'hFE, 5'h1E);
      col_is("cmp_up_7",  8'hEF, 5'h17);
      send(8'hE0); send(8'hF0); send(8'h75);
      col_is("cmp_up_rel", 8'hFE, 5'h1F);

      // Overlap: held CS survives a compound release
      send(8'h12); send(8'h66);
      col_is("bksp_0", 8'hEF, 5'h1E);
      send(8'hF0); send(8'h66);
      col_is("overlap_cs", 8'hFE, 5'h1E);
      col_is("overlap_0",  8'hEF, 5'h1F);
      send(8'hF0); send(8'h12);
      col_is("overlap_rel", 8'hFE, 5'h1F);

      // Pause sequence has no effect, then normal decoding resumes
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      col_is("pause_none", 8'h00, 5'h1F);
      send(8'h1A);
      col_is("pause_after", 8'hFE, 5'h1D);
      send(8'hF0); send(8'h1A);

      // Fake shift ignored
      send(8'hE0); send(8'h12);
      col_is("fake_shift", 8'hFE, 5'h1F);

      // Hot-plug clears everything; F12 and F5
      send(8'h1C); send(8'h29); send(8'h03);
      col_is("hold_two", 8'h00, 5'h1E);
      chk("nmi_held", {7'b0, bus.nmi}, 8'h01);
      send(8'hAA);
      col_is("bat_clear", 8'h00, 5'h1F);
      chk("nmi_bat", {7'b0, bus.nmi}, 8'h00);
      send(8'h07);
      chk("boot_on", {7'b0, bus.boot}, 8'h01);
      send(8'hF0); send(8'h07);
      chk("boot_off", {7'b0, bus.boot}, 8'h00);

      // Reset mid-sequence discards the pending F0
      send(8'hF0);
      do_reset();
      send(8'h1C);
      col_is("post_reset", 8'hFD, 5'h1E);
      send(8'hF0); send(8'h1C);

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
         op = int'($urandom_range(0, 19));
         if (op < 10) begin
            press(pool[$urandom_range(0, pool.size() - 1)]);
         end else if (op < 16) begin
            release_key(pool[$urandom_range(0, pool.size() - 1)]);
         end else if (op < 18) begin
            send(noise[$urandom_range(0, 4)]);
         end else if (op == 18) begin
            send(8'hE1);
            for (int j = 0; j < SKIP; j++) send(8'($urandom_range(0, 255)));
         end else begin
            if ($urandom_range(0, 3) == 0) send(8'hAA);
            else begin
               @(posedge clock); #1;
            end
         end
         rsel = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rsel = 8'h00;
         col_is("rand_col", rsel, model_col(rsel));
         chk("rand_nmi",  {7'b0, bus.nmi},  {7'b0, held.exists('h003)});
         chk("rand_boot", {7'b0, bus.boot}, {7'b0, held.exists('h007)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/keymatrix.md
# keymatrix

Converts the PS/2 receiver's byte stream into a live ZX Spectrum 8×5 keyboard matrix, answered against the CPU's high address byte. Sits directly downstream of the PS/2 receiver, consuming its `strb`/`code` pair, and feeds the ULA port-FE read path.
- Tracks set-2 prefixes (E0, F0, E1) in a small state machine.
- Holds one bit per matrix position plus separate flags for compound keys.
- Returns active-low column data for whichever rows are selected.

## Interface
Parameters:
- `SKIP_E1`, default 7: bytes swallowed after an E1 (Pause) prefix.

Ports:
- `clock`  in  1  system clock; the block's single clock.
- `reset`  in  1  synchronous, active-high reset.
- `strb`  in  1  one-cycle pulse: `code` holds a valid received byte.
- `code`  in  8  received set-2 scancode byte.
- `row`  in  8  CPU A[15:8]; a row is selected when its bit is 0.
- `col`  out  5  active-low key data D[4:0] for the selected rows.
- `nmi`  out  1  high while F5 (03) is held.
- `boot`  out  1  high while F12 (07) is held.

## Operation
- **Prefix FSM states:** IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0), SKIP.
  - E0 in IDLE goes to EXT.
  - F0 in IDLE goes to BRK; F0 in EXT goes to EXTBRK.
  - Any other byte applies press (IDLE/EXT) or release (BRK/EXTBRK), then returns to IDLE.
  - The extended flag is set in EXT/EXTBRK.
- **E1 (Pause):** E1 in IDLE loads the skip counter with `SKIP_E1` and enters SKIP. Each strobe decrements the counter; the byte after which it reaches 0 returns the FSM to IDLE. Bytes seen in SKIP have no effect.
- **Non-key bytes:** AA, FA, EE, FE, 00 and FF are never keys.
  - AA in IDLE clears every key bit, every compound flag, `nmi` and `boot` (keyboard hot-plug/BAT).
  - The others leave state unchanged and return the FSM to IDLE.
- **Matrix rows:** row r, bit 0 is the outermost key.
  - 0 CS Z X C V; 1 A S D F G; 2 Q W E R T; 3 1 2 3 4 5; 4 0 9 8 7 6; 5 P O I U Y; 6 Enter L K J H; 7 Space SS M N B.
- **Direct map:**
  - CS: 12, 59.
  - SS: 14 and E0 14.
  - Enter: 5A and E0 5A.
  - Space: 29.
  - Letters A–Z and digits 0–9 use their standard set-2 codes (e.g. A=1C, Z=1A, 1=16, 0=45).
- **Compound flags:** each sets CS plus one key.
  - Backspace 66 = CS+0.
  - E0 6B = CS+5, E0 72 = CS+6, E0 75 = CS+7, E0 74 = CS+8.
- **Effective matrix:** the direct bits ORed with the compound contributions. Releasing a compound key never clears a physically held CS.
- **Ignored codes:**
  - Unmapped codes, with or without E0.
  - E0 12 (fake shift).
  - Releases of keys not held.
- **Column output:** `col[c]` = NOT (OR over rows r with `row[r]`=0 of effective bit [r][c]). `row`=FF gives 1F.

## Timing
- **Reset values:** `col`=1F; `nmi`=0; `boot`=0; FSM=IDLE; skip counter=0; all key bits and flags clear. Reset mid-sequence discards any pending prefix.
- **State update:** key state, flags, `nmi` and `boot` update on the clock edge that samples `strb`=1.
- **Column output:** `col` is registered from the current key state and `row`.
  - Latency from `row` to `col` is 1 cycle.
  - Latency from `strb` to `col` is 2 cycles.
- **Back-to-back strobes:** handled on consecutive cycles; each byte is processed in order.
- **Strobe during SKIP:** always decrements the counter and never underflows.

## Structure
- **`keymatrix_pkg`:**
  - FSM state enum.
  - Prefix constants E0/F0/E1/AA.
  - The scancode→(row, col) constant table.
  - Compound-key constants.
- **`keymatrix_decode` sub-module:** combinational lookup of (extended, code) → {valid, row[2:0], col[2:0], compound id, nmi/boot select}.
- **`keymatrix` top:** the FSM, skip counter, state registers and column reduction.

## Test plan
- **Reset:** reset; `row`=00 → `col`=1F, `nmi`=0, `boot`=0.
- **Direct key:** press 1C; `row`=FD → `col`=1E. Then F0 1C → `col`=1F.
- **Compound key:** E0 75; `row`=FE → `col`=1E; `row`=EF → `col`=17. Then E0 F0 75; `row`=FE → `col`=1F.
- **Overlap:** press 12, press 66, send F0 66; `row`=FE → `col`=1E, CS still held. Then F0 12 → `col`=1F.
- **Pause:** E1 14 77 E1 F0 14 F0 77 → no matrix change. Then 1A; `row`=FE → `col`=1D.
- **Hot-plug and F12:** hold 1C and 29, then send AA; `row`=00 → `col`=1F. Then 07 → `boot`=1; F0 07 → `boot`=0.
